// File: rtl/spi_pkg.sv
// Shared constants, types and edge-selection helpers for the word-wide SPI slave.
package spi_pkg;

  localparam int unsigned SPI_MODE_0 = 0;
  localparam int unsigned SPI_MODE_1 = 1;
  localparam int unsigned SPI_MODE_2 = 2;
  localparam int unsigned SPI_MODE_3 = 3;

  localparam int unsigned MAX_WORD_WIDTH = 32;

  typedef enum logic {
    ST_IDLE,
    ST_ACTIVE
  } spi_state_t;

  // CPHA=0 samples on the leading edge, CPHA=1 on the trailing edge.
  function automatic logic sample_on_leading(input logic [1:0] mode);
    return !mode[0];
  endfunction

  // Idle level of SCK for the given mode.
  function automatic logic mode_cpol(input logic [1:0] mode);
    return mode[1];
  endfunction

endpackage

// File: rtl/spi_slave_word_if.sv
// Word-side handshake bundle between the SPI slave and the command decoder.
interface spi_slave_word_if #(
  parameter int unsigned WORD_WIDTH = 8
);

  logic                  o_rx_data_valid;
  logic [WORD_WIDTH-1:0] o_rx_word;
  logic                  o_rx_abort;
  logic                  i_tx_data_valid;
  logic [WORD_WIDTH-1:0] i_tx_word;
  logic                  o_tx_ready;
  logic                  o_tx_underrun;
  logic                  o_cs_active;

  modport slave (
    output o_rx_data_valid, o_rx_word, o_rx_abort,
    output o_tx_ready, o_tx_underrun, o_cs_active,
    input  i_tx_data_valid, i_tx_word
  );

  modport master (
    input  o_rx_data_valid, o_rx_word, o_rx_abort,
    input  o_tx_ready, o_tx_underrun, o_cs_active,
    output i_tx_data_valid, i_tx_word
  );

endinterface

// File: rtl/spi_pin_sync.sv
// Multi-flop input synchroniser with a history flop for rise/fall strobes.
module spi_pin_sync #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic        RESET_VALUE = 1'b0
) (
  input  logic i_sys_clk,
  input  logic i_reset,
  input  logic i_pin,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;

  // Shift the pin through the synchroniser chain and keep one cycle of history.
  always_ff @(posedge i_sys_clk or posedge i_reset) begin
    if (i_reset) begin
      sync_q <= {SYNC_STAGES{RESET_VALUE}};
      hist_q <= RESET_VALUE;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], i_pin};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign o_level = sync_q[SYNC_STAGES-1];
  assign o_rise  = o_level & ~hist_q;
  assign o_fall  = ~o_level & hist_q;

endmodule

// File: rtl/spi_slave_word.sv
// Oversampled SPI slave: configurable mode, word width, bit order and TX underrun fill.
module spi_slave_word
  import spi_pkg::*;
#(
  parameter int unsigned           WORD_WIDTH  = 8,
  parameter int unsigned           SPI_MODE    = 0,
  parameter int unsigned           MSB_FIRST   = 1,
  parameter logic [WORD_WIDTH-1:0] TX_FILL     = '0,
  parameter int unsigned           SYNC_STAGES = 2
) (
  input  logic              i_sys_clk,
  input  logic              i_reset,
  input  logic              i_spi_sck,
  input  logic              i_spi_cs_b,
  input  logic              i_spi_mosi,
  output logic              o_spi_miso,
  spi_slave_word_if.slave   bus
);

  localparam logic [1:0]             MODE     = 2'(SPI_MODE);
  localparam logic                   CPOL     = mode_cpol(MODE);
  localparam logic                   LEAD_SMP = sample_on_leading(MODE);
  localparam bit                     MSB      = (MSB_FIRST != 0);
  localparam int unsigned            CNT_W    = $clog2(WORD_WIDTH);
  localparam logic [CNT_W-1:0]       LAST_CNT = CNT_W'(WORD_WIDTH - 1);

  logic sck_level, sck_rise, sck_fall;
  logic cs_b_level, cs_rise, cs_fall;
  logic mosi_level, mosi_rise, mosi_fall;

  spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VALUE(CPOL)) u_sync_sck (
    .i_sys_clk(i_sys_clk), .i_reset(i_reset), .i_pin(i_spi_sck),
    .o_level(sck_level), .o_rise(sck_rise), .o_fall(sck_fall)
  );

  spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VALUE(1'b1)) u_sync_cs (
    .i_sys_clk(i_sys_clk), .i_reset(i_reset), .i_pin(i_spi_cs_b),
    .o_level(cs_b_level), .o_rise(cs_rise), .o_fall(cs_fall)
  );

  spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VALUE(1'b0)) u_sync_mosi (
    .i_sys_clk(i_sys_clk), .i_reset(i_reset), .i_pin(i_spi_mosi),
    .o_level(mosi_level), .o_rise(mosi_rise), .o_fall(mosi_fall)
  );

  logic unused_sync;
  assign unused_sync = ^{sck_level, mosi_rise, mosi_fall};

  spi_state_t            state_q;
  logic [CNT_W-1:0]      bit_cnt_q;
  logic [WORD_WIDTH-1:0] rx_shift_q, rx_word_q, tx_shift_q, hold_q;
  logic                  hold_full_q, miso_q, rx_valid_q, rx_abort_q, underrun_q;

  logic                  leading, trailing, sample_edge, shift_edge;
  logic                  tx_load, handshake;
  logic [WORD_WIDTH-1:0] rx_next, load_word;

  // Decode SCK strobes into sample/shift events and the TX load/handshake conditions.
  always_comb begin
    leading     = CPOL ? sck_fall : sck_rise;
    trailing    = CPOL ? sck_rise : sck_fall;
    sample_edge = LEAD_SMP ? leading : trailing;
    shift_edge  = LEAD_SMP ? trailing : leading;
    rx_next     = MSB ? {rx_shift_q[WORD_WIDTH-2:0], mosi_level}
                      : {mosi_level, rx_shift_q[WORD_WIDTH-1:1]};
    load_word   = hold_full_q ? hold_q : TX_FILL;
    handshake   = bus.i_tx_data_valid && !hold_full_q;
    // A shift edge with a zero count is a word boundary in both phases; CPHA=0 also loads at CS fall.
    tx_load     = ((state_q == ST_IDLE) && cs_fall && LEAD_SMP) ||
                  ((state_q == ST_ACTIVE) && !cs_rise && shift_edge && (bit_cnt_q == '0));
  end

  // Frame FSM, RX/TX shift datapath and TX holding register.
  always_ff @(posedge i_sys_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      rx_shift_q  <= '0;
      rx_word_q   <= '0;
      tx_shift_q  <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      miso_q      <= 1'b0;
      rx_valid_q  <= 1'b0;
      rx_abort_q  <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      rx_abort_q <= 1'b0;
      underrun_q <= 1'b0;

      if (tx_load) begin
        underrun_q <= !hold_full_q;
        miso_q     <= MSB ? load_word[WORD_WIDTH-1] : load_word[0];
        tx_shift_q <= MSB ? (load_word << 1) : (load_word >> 1);
      end

      if (handshake) begin
        hold_q      <= bus.i_tx_word;
        hold_full_q <= 1'b1;
      end else if (tx_load) begin
        hold_full_q <= 1'b0;
      end

      case (state_q)
        ST_IDLE: begin
          if (cs_fall) begin
            state_q   <= ST_ACTIVE;
            bit_cnt_q <= '0;
          end
        end
        ST_ACTIVE: begin
          if (cs_rise) begin
            rx_abort_q <= (bit_cnt_q != '0);
            bit_cnt_q  <= '0;
            rx_shift_q <= '0;
            miso_q     <= 1'b0;
            state_q    <= ST_IDLE;
          end else begin
            if (sample_edge) begin
              rx_shift_q <= rx_next;
              if (bit_cnt_q == LAST_CNT) begin
                bit_cnt_q  <= '0;
                rx_word_q  <= rx_next;
                rx_valid_q <= 1'b1;
              end else begin
                bit_cnt_q <= bit_cnt_q + 1'b1;
              end
            end
            if (shift_edge && (bit_cnt_q != '0)) begin
              miso_q     <= MSB ? tx_shift_q[WORD_WIDTH-1] : tx_shift_q[0];
              tx_shift_q <= MSB ? (tx_shift_q << 1) : (tx_shift_q >> 1);
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign o_spi_miso          = miso_q;
  assign bus.o_rx_data_valid = rx_valid_q;
  assign bus.o_rx_word       = rx_word_q;
  assign bus.o_rx_abort      = rx_abort_q;
  assign bus.o_tx_ready      = !hold_full_q;
  assign bus.o_tx_underrun   = underrun_q;
  assign bus.o_cs_active     = !cs_b_level;

endmodule
